tictactoe_board_display: RTL
============================

# tictactoe_board_display

Downstream consumer of the `tictactoe` core. It captures each accepted move from `xoroout`/`rowout`/`colout` into a local 3x3 board mirror and scans that mirror onto a row-multiplexed bi-colour 3x3 LED matrix. It also tracks game-over and error status and keeps saturating win/draw tallies across games. It sits between the core outputs and the board-level LED and 7-segment drivers.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row stays selected; legal range ≥1.
- `BLINK_DIV`, default 8: full scan frames per blink-phase toggle; legal range ≥1.
- `SCORE_W`, default 4: width of each tally counter.
- `ph1` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `xoroout` in 2: mover. `01` = X, `10` = O, `00` = no move this cycle, `11` = illegal.
- `rowout` in 2: move row, 0..2.
- `colout` in 2: move column, 0..2.
- `win` in 2: `00` = none, `01` = X wins, `10` = O wins, `11` = draw.
- `err` in 1: core error flag.
- `clr` in 1: synchronous new-game request; clears the board and error, keeps the tallies.
- `row_sel` out 3: one-hot LED row strobe.
- `led_x` out 3: X cells of the selected row; bit *c* = column *c*.
- `led_o` out 3: O cells of the selected row; bit *c* = column *c*.
- `err_led` out 1: sticky error indicator.
- `game_over` out 1: high while in OVER.
- `x_score` out SCORE_W: X win tally.
- `o_score` out SCORE_W: O win tally.
- `draw_count` out SCORE_W: draw tally.

## Operation
- **Board:** 9 cells, 2 bits each, same encoding as `xoroout`.
- **Reset values:** all cells `00`; state PLAY; `win_armed`=1; `row_sel`=`001`; `led_x`=`led_o`=`000`; `err_led`=0; `game_over`=0; all tallies 0; scan, divider and frame counters 0; blink phase on.
- **PLAY, move:** a move is `xoroout` ∈ {`01`,`10`}.
  - With `rowout`<3, `colout`<3 and the target cell empty, the cell is written.
  - With either coordinate =3, or the target cell already occupied, no write; `err_led` is set.
  - `xoroout`=`11` sets `err_led`.
- **Error:** `err`=1 in any state sets `err_led`. `err_led` clears only on `clr` or reset.
- **PLAY to OVER:** taken when `win`≠`00` and `win_armed`=1.
  - The matching tally increments once, saturating at all-ones.
  - `win_armed` is cleared.
  - A legal move in that same cycle is still written first.
- **OVER:** board frozen; all moves ignored; `game_over`=1. LED outputs are gated by the blink phase: when the phase is off, `led_x`=`led_o`=0 while `row_sel` keeps scanning.
- **`win_armed`:** set again whenever `win` is sampled as `00`. This prevents a `win` held across `clr` from double-counting.
- **`clr`:** clears the board and `err_led` and forces PLAY from any state. It has priority over a move, `win` or `err` in the same cycle.
- **Scan:**
  - The divider counts 0..SCAN_DIV-1.
  - At terminal count the row advances 0→1→2→0; `row_sel` = `1<<row`.
  - Each 2→0 wrap increments the frame counter.
  - Every BLINK_DIV frames the blink phase toggles and the frame counter clears.
  - Scanning runs in both states and is unaffected by `clr`.

## Timing
- All outputs are registered.
- A cell written at edge *n* appears on `led_x`/`led_o` at edge *n+1* if its row is selected at that time; otherwise at the next visit of that row.
- `game_over` and the tally update are visible 1 cycle after `win` is sampled.
- `err_led` rises 1 cycle after the offending input.
- `row_sel` and the LED data for the same row change on the same edge, so there is no ghosting.
- Scan period = 3·SCAN_DIV cycles.
- Blink half-period = 3·SCAN_DIV·BLINK_DIV cycles.
- Reset assertion takes effect immediately (asynchronous). Release takes effect on the next `ph1` edge.

## Structure
- Shared package `tictactoe_pkg`:
  - `xoro_t` enum: EMPTY, X, O, BAD.
  - `win_t` enum: NONE, XWIN, OWIN, DRAW.
  - `disp_state_t`: PLAY, OVER.
  - Constant `BOARD_N`=3.
- One sub-module, `led_scan_timer`: owns the row, divider, frame and blink counters; outputs `row` and `blink_on`.
- The board, the FSM and the tallies stay in the top module.

## Test plan
- **Single move:** reset, then X move (row 1, col 2) for one cycle → within ≤3·SCAN_DIV cycles, `row_sel`=`010` with `led_x`=`100`; `err_led`=0.
- **Occupied cell:** O move to (1,2) after the X move → board unchanged; `err_led`=1 one cycle later; stays 1 until `clr`.
- **Bad coordinate:** move with `rowout`=3 → no write; `err_led`=1.
- **Win held 5 cycles:** `win`=`01` for 5 cycles, then `clr`, with `win` still `01` for 2 more cycles → `x_score`=1 (not 2); `game_over` 1→0 on the cycle after `clr`.
- **Game over:** in OVER, legal moves are ignored; LEDs go dark for 3·SCAN_DIV·BLINK_DIV cycles and then return; after `clr` the board is empty.
- **Saturation and mid-operation reset:** 16 draws with SCORE_W=4 → `draw_count`=15. Asserting `reset_n`=0 mid-scan immediately sets all outputs to their reset values.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared cell, win and display-state encodings for the board display
package tictactoe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10, BAD = 2'b11} xoro_t;
    typedef enum logic [1:0] {NONE = 2'b00, XWIN = 2'b01, OWIN = 2'b10, DRAW = 2'b11} win_t;
    typedef enum logic {PLAY = 1'b0, OVER = 1'b1} disp_state_t;
    localparam int BOARD_N = 3;
endpackage

// File: rtl/led_scan_timer.sv
// led_scan_timer: row scan divider and blink phase generator
// Ports: ph1 clock, reset_n async active-low reset, row = currently scanned row (0..2),
//        blink_on = blink phase (1 = lit)
module led_scan_timer #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic       ph1,
    input  logic       reset_n,
    output logic [1:0] row,
    output logic       blink_on
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int FW = $clog2(BLINK_DIV + 1);
    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [1:0]    row_q, row_d;
    logic          blink_q, blink_d, tc, wrap, fend;
    always_comb begin
        tc      = div_q == DW'(SCAN_DIV - 1);
        wrap    = tc && row_q == 2'd2;
        fend    = wrap && frame_q == FW'(BLINK_DIV - 1);
        div_d   = tc ? '0 : div_q + DW'(1);
        row_d   = tc ? (row_q == 2'd2 ? 2'd0 : row_q + 2'd1) : row_q;
        frame_d = fend ? '0 : wrap ? frame_q + FW'(1) : frame_q;
        blink_d = fend ? ~blink_q : blink_q;
    end
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end
    assign row      = row_q;
    assign blink_on = blink_q;
endmodule

// File: rtl/tictactoe_board_display.sv
// tictactoe_board_display: board mirror, game status and tallies scanned onto a 3x3 bi-colour LED matrix
// Ports: ph1/reset_n clock and async active-low reset; xoroout/rowout/colout move from the core;
//        win/err core status; clr new game; row_sel/led_x/led_o matrix drive; err_led, game_over,
//        x_score/o_score/draw_count status and saturating tallies
module tictactoe_board_display
    import tictactoe_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8,
    parameter int SCORE_W   = 4
) (
    input  logic               ph1,
    input  logic               reset_n,
    input  logic [1:0]         xoroout,
    input  logic [1:0]         rowout,
    input  logic [1:0]         colout,
    input  logic [1:0]         win,
    input  logic               err,
    input  logic               clr,
    output logic [2:0]         row_sel,
    output logic [2:0]         led_x,
    output logic [2:0]         led_o,
    output logic               err_led,
    output logic               game_over,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] draw_count
);
    logic [8:0][1:0]    board_q, board_d;
    disp_state_t        state_q, state_d;
    logic               armed_q, armed_d, err_q, err_d;
    logic [SCORE_W-1:0] xs_q, xs_d, os_q, os_d, ds_q, ds_d;
    logic [2:0]         row_sel_q, row_sel_d, led_x_q, led_x_d, led_o_q, led_o_d;
    logic [1:0]         row;
    logic               blink_on, dark, is_move, coord_ok;
    logic [3:0]         idx, cell_idx;
    xoro_t              mv;
    win_t               wn;

    led_scan_timer #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) u_timer (
        .ph1      (ph1),
        .reset_n  (reset_n),
        .row      (row),
        .blink_on (blink_on)
    );

    always_comb begin
        mv       = xoro_t'(xoroout);
        wn       = win_t'(win);
        is_move  = mv == X || mv == O;
        coord_ok = rowout != 2'd3 && colout != 2'd3;
        idx      = 4'(rowout) * 4'(BOARD_N) + 4'(colout);
        board_d  = board_q;
        state_d  = state_q;
        armed_d  = armed_q;
        err_d    = err_q;
        xs_d     = xs_q;
        os_d     = os_q;
        ds_d     = ds_q;
        if (clr) begin
            board_d = '0;
            err_d   = 1'b0;
            state_d = PLAY;
        end else begin
            if (err) err_d = 1'b1;
            if (state_q == PLAY) begin
                if (is_move) begin
                    if (coord_ok && board_q[idx] == EMPTY) board_d[idx] = xoroout;
                    else err_d = 1'b1;
                end
                if (mv == BAD) err_d = 1'b1;
                if (wn != NONE && armed_q) begin
                    state_d = OVER;
                    armed_d = 1'b0;
                    if (wn == XWIN && xs_q != '1) xs_d = xs_q + SCORE_W'(1);
                    if (wn == OWIN && os_q != '1) os_d = os_q + SCORE_W'(1);
                    if (wn == DRAW && ds_q != '1) ds_d = ds_q + SCORE_W'(1);
                end
            end
        end
        // a sampled "no result" re-arms counting, so a win held across clr counts once
        if (wn == NONE) armed_d = 1'b1;
        // strobe and data come from the same row value so they switch on the same edge
        dark      = state_q == OVER && !blink_on;
        row_sel_d = 3'b001 << row;
        led_x_d   = '0;
        led_o_d   = '0;
        cell_idx  = '0;
        for (int c = 0; c < BOARD_N; c++) begin
            cell_idx   = 4'(row) * 4'(BOARD_N) + 4'(c);
            led_x_d[c] = !dark && board_q[cell_idx] == X;
            led_o_d[c] = !dark && board_q[cell_idx] == O;
        end
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            board_q   <= '0;
            state_q   <= PLAY;
            armed_q   <= 1'b1;
            err_q     <= 1'b0;
            xs_q      <= '0;
            os_q      <= '0;
            ds_q      <= '0;
            row_sel_q <= 3'b001;
            led_x_q   <= '0;
            led_o_q   <= '0;
        end else begin
            board_q   <= board_d;
            state_q   <= state_d;
            armed_q   <= armed_d;
            err_q     <= err_d;
            xs_q      <= xs_d;
            os_q      <= os_d;
            ds_q      <= ds_d;
            row_sel_q <= row_sel_d;
            led_x_q   <= led_x_d;
            led_o_q   <= led_o_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign led_x      = led_x_q;
    assign led_o      = led_o_q;
    assign err_led    = err_q;
    assign game_over  = state_q == OVER;
    assign x_score    = xs_q;
    assign o_score    = os_q;
    assign draw_count = ds_q;
endmodule
